clk_tick_gen: RTL and testbench

Parametrised successor to the fixed 50 MHz→1 Hz divider chain. It turns the board clock CLK into a prescaled base rate and N_DEC cascaded decade stages. Each stage provides two outputs: a single-CLK-cycle tick enable, and a 50 %-duty square wave. All logic runs in the CLK domain, with no derived clocks. It feeds the clock/timekeeping counters and display multiplexing. Runtime controls are enable, synchronous clear and a fast simulation/test mode.

---
 rtl/clk_pkg.sv | 41 ++++
 rtl/decade_stage.sv | 58 +++++
 rtl/clk_tick_gen.sv | 94 +++++++++
 tb/tb_clk_tick_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants and elaboration helpers for the tick generator.
//   DEC_MOD / DEC_W : decade stage modulus and counter width
//   clog2()         : ceiling log2, used to size the prescaler counter
//   calc_p()        : prescaler ratio P = CLK_HZ / BASE_HZ
//   params_ok()     : legality of a parameter set, checked at elaboration
package clk_pkg;

  localparam int DEC_MOD = 10;
  localparam int DEC_W   = 4;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int calc_p(input int clk_hz, input int base_hz);
    return (base_hz > 0) ? clk_hz / base_hz : 0;
  endfunction

  // P must divide evenly, be even and >= 2; FAST_DIV likewise and no
  // larger than P so a fast-mode counter never needs more bits than P.
  function automatic bit params_ok(input int clk_hz, input int base_hz,
                                   input int n_dec, input int fast_div);
    int p;
    if (base_hz <= 0 || clk_hz <= 0) return 1'b0;
    if ((clk_hz % base_hz) != 0)    return 1'b0;
    p = clk_hz / base_hz;
    if (p < 2 || (p % 2) != 0)      return 1'b0;
    if (n_dec < 1 || n_dec > 9)     return 1'b0;
    if (fast_div < 2 || (fast_div % 2) != 0 || fast_div > p) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/decade_stage.sv
// One divide-by-10 stage of the tick chain.
//   CLK, RST  : clock, asynchronous active-low reset
//   en        : count enable (low holds dcnt and sqw, forces tick low)
//   clr       : synchronous clear of dcnt, tick, sqw
//   carry_in  : single-cycle carry from the previous stage
//   carry_out : combinational carry to the next stage (carry_in at dcnt==9)
//   tick      : registered carry_out, aligned with all lower-stage ticks
//   sqw       : registered (next dcnt >= 5), 50 % duty
module decade_stage
  import clk_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  input  logic carry_in,
  output logic carry_out,
  output logic tick,
  output logic sqw
);

  localparam logic [DEC_W-1:0] LAST = DEC_W'(DEC_MOD - 1);
  localparam logic [DEC_W-1:0] HALF = DEC_W'(DEC_MOD / 2);

  logic [DEC_W-1:0] dcnt;
  logic [DEC_W-1:0] dcnt_nxt;

  // NOTE: every signal gets a default before the conditional logic so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dcnt_nxt  = dcnt;
    carry_out = carry_in && (dcnt == LAST);
    if (carry_in) begin
      dcnt_nxt = (dcnt == LAST) ? '0 : dcnt + DEC_W'(1);
    end
  end

  // NOTE: non-blocking assignments make every register sample the
  // pre-edge values, so the stages update together without ordering races.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dcnt <= '0;
      tick <= 1'b0;
      sqw  <= 1'b0;
    end else if (clr) begin
      dcnt <= '0;
      tick <= 1'b0;
      sqw  <= 1'b0;
    end else if (en) begin
      dcnt <= dcnt_nxt;
      tick <= carry_out;
      sqw  <= (dcnt_nxt >= HALF);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// Prescaler plus N_DEC cascaded decade stages, all in the CLK domain.
//   CLK      : system clock
//   RST      : asynchronous, active-low reset
//   EN       : count enable; low freezes all counters and silences TICK
//   SYNC_CLR : synchronous clear of all counters and outputs (beats EN)
//   FAST     : 1 = prescaler divides by FAST_DIV instead of P
//   TICK     : [0] base-rate enable, [k] stage-k enable, one cycle wide
//   SQW      : registered 50 % duty square wave per stage
module clk_tick_gen
  import clk_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BASE_HZ  = 1_000_000,
  parameter int N_DEC    = 6,
  parameter int FAST_DIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SYNC_CLR,
  input  logic             FAST,
  output logic [N_DEC:0]   TICK,
  output logic [N_DEC:0]   SQW
);

  localparam int P      = calc_p(CLK_HZ, BASE_HZ);
  localparam int PCNT_W = (clog2(P) < 1) ? 1 : clog2(P);

  localparam logic [PCNT_W-1:0] P_LAST    = PCNT_W'(P - 1);
  localparam logic [PCNT_W-1:0] P_HALF    = PCNT_W'(P / 2);
  localparam logic [PCNT_W-1:0] FAST_LAST = PCNT_W'(FAST_DIV - 1);
  localparam logic [PCNT_W-1:0] FAST_HALF = PCNT_W'(FAST_DIV / 2);

  if (!params_ok(CLK_HZ, BASE_HZ, N_DEC, FAST_DIV)) begin : g_param_check
    $error("clk_tick_gen: illegal parameters CLK_HZ=%0d BASE_HZ=%0d N_DEC=%0d FAST_DIV=%0d",
           CLK_HZ, BASE_HZ, N_DEC, FAST_DIV);
  end

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_nxt;
  logic [PCNT_W-1:0] d_last;
  logic [PCNT_W-1:0] d_half;
  logic              pwrap;
  logic              tick_base;
  logic              sqw_base;
  logic [N_DEC:0]    carry;
  logic [N_DEC:1]    tick_dec;
  logic [N_DEC:1]    sqw_dec;

  // Wrapping on ">=" rather than "==" means a switch to a shorter ratio
  // mid-count terminates immediately instead of running past the end.
  always_comb begin
    d_last   = FAST ? FAST_LAST : P_LAST;
    d_half   = FAST ? FAST_HALF : P_HALF;
    pwrap    = (pcnt >= d_last);
    pcnt_nxt = pwrap ? '0 : pcnt + PCNT_W'(1);
    carry[0] = EN && !SYNC_CLR && pwrap;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pcnt      <= '0;
      tick_base <= 1'b0;
      sqw_base  <= 1'b0;
    end else if (SYNC_CLR) begin
      pcnt      <= '0;
      tick_base <= 1'b0;
      sqw_base  <= 1'b0;
    end else if (EN) begin
      pcnt      <= pcnt_nxt;
      tick_base <= pwrap;
      sqw_base  <= (pcnt_nxt >= d_half);
    end else begin
      tick_base <= 1'b0;
    end
  end

  for (genvar k = 1; k <= N_DEC; k++) begin : g_dec
    decade_stage u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .en        (EN),
      .clr       (SYNC_CLR),
      .carry_in  (carry[k-1]),
      .carry_out (carry[k]),
      .tick      (tick_dec[k]),
      .sqw       (sqw_dec[k])
    );
  end

  assign TICK = {tick_dec, tick_base};
  assign SQW  = {sqw_dec, sqw_base};

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen with CLK_HZ=100, BASE_HZ=10, N_DEC=2,
// FAST_DIV=2 (P=10). Edge numbers count rising edges after RST release;
// outputs are sampled 1 time unit after each rising edge.
module tb_clk_tick_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       SYNC_CLR;
  logic       FAST;
  logic [2:0] TICK;
  logic [2:0] SQW;

  int checks = 0;
  int errors = 0;

  clk_tick_gen #(
    .CLK_HZ   (100),
    .BASE_HZ  (10),
    .N_DEC    (2),
    .FAST_DIV (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .SYNC_CLR (SYNC_CLR),
    .FAST     (FAST),
    .TICK     (TICK),
    .SQW      (SQW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Assert reset, then release it between edges so the next edge is edge 1.
  task automatic do_reset(input logic fast_mode);
    RST      = 1'b0;
    EN       = 1'b1;
    SYNC_CLR = 1'b0;
    FAST     = fast_mode;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tick", TICK, 3'b000);
    check("reset_sqw", SQW, 3'b000);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    int   n0, n1, n2;
    logic [2:0] seen;

    // ---- Reset and basic rate / square waves ----
    do_reset(1'b0);
    adv(4);    check("e4_sqw", SQW, 3'b000);
    adv(1);    check("e5_sqw", SQW, 3'b001);
    adv(4);    check("e9_tick", TICK, 3'b000);
               check("e9_sqw", SQW, 3'b001);
    adv(1);    check("e10_tick", TICK, 3'b001);
               check("e10_sqw", SQW, 3'b000);
    adv(1);    check("e11_tick", TICK, 3'b000);
    adv(39);   check("e50_tick", TICK, 3'b001);
               check("e50_sqw", SQW, 3'b010);
    adv(49);   check("e99_tick", TICK, 3'b000);
               check("e99_sqw", SQW, 3'b011);
    adv(1);    check("e100_tick", TICK, 3'b011);
               check("e100_sqw", SQW, 3'b000);
    adv(400);  check("e500_tick", TICK, 3'b011);
               check("e500_sqw", SQW, 3'b100);
    adv(499);  check("e999_tick", TICK, 3'b000);
               check("e999_sqw", SQW, 3'b111);
    adv(1);    check("e1000_tick", TICK, 3'b111);
               check("e1000_sqw", SQW, 3'b000);
    // Edges 1001..1100: ten base ticks, one stage-1 tick, no stage-2 tick.
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 100; i++) begin
      adv(1);
      n0 += int'(TICK[0]);
      n1 += int'(TICK[1]);
      n2 += int'(TICK[2]);
    end
    check("win_tick0", 3'(n0), 3'(10));
    check("win_tick1", 3'(n1), 3'd1);
    check("win_tick2", 3'(n2), 3'd0);

    // ---- Async reset mid-run ----
    do_reset(1'b0);
    adv(512);  check("e512_sqw", SQW, 3'b100);
    RST = 1'b0;
    #1;        check("async_tick", TICK, 3'b000);
               check("async_sqw", SQW, 3'b000);
    @(negedge CLK);
    RST = 1'b1;
    adv(5);    check("rst2_e5_sqw", SQW, 3'b001);
    adv(4);    check("rst2_e9_tick", TICK, 3'b000);
    adv(1);    check("rst2_e10_tick", TICK, 3'b001);

    // ---- Enable hold: edges 24..60 disabled ----
    do_reset(1'b0);
    adv(23);   check("hold_e23_sqw", SQW, 3'b000);
    EN = 1'b0;
    seen = 3'b000;
    for (int i = 0; i < 37; i++) begin
      adv(1);
      seen |= TICK;
    end
    check("hold_no_tick", seen, 3'b000);
    check("hold_sqw", SQW, 3'b000);
    EN = 1'b1;
    adv(2);    check("hold_e62_sqw", SQW, 3'b001);
    adv(4);    check("hold_e66_tick", TICK, 3'b000);
    adv(1);    check("hold_e67_tick", TICK, 3'b001);
               check("hold_e67_sqw", SQW, 3'b000);

    // ---- Synchronous clear at edge 55 ----
    do_reset(1'b0);
    adv(54);   check("clr_e54_sqw", SQW, 3'b010);
    SYNC_CLR = 1'b1;
    adv(1);    check("clr_e55_tick", TICK, 3'b000);
               check("clr_e55_sqw", SQW, 3'b000);
    SYNC_CLR = 1'b0;
    adv(9);    check("clr_e64_tick", TICK, 3'b000);
    adv(1);    check("clr_e65_tick", TICK, 3'b001);
    adv(89);   check("clr_e154_tick", TICK, 3'b000);
    adv(1);    check("clr_e155_tick", TICK, 3'b011);

    // ---- Fast mode from reset ----
    do_reset(1'b1);
    adv(1);    check("fast_e1_tick", TICK, 3'b000);
               check("fast_e1_sqw", SQW, 3'b001);
    adv(1);    check("fast_e2_tick", TICK, 3'b001);
    adv(17);   check("fast_e19_tick", TICK, 3'b000);
    adv(1);    check("fast_e20_tick", TICK, 3'b011);
    adv(180);  check("fast_e200_tick", TICK, 3'b111);

    // ---- FAST raised while pcnt=7 ----
    do_reset(1'b0);
    adv(7);    check("sw_e7_tick", TICK, 3'b000);
    FAST = 1'b1;
    adv(1);    check("sw_e8_tick", TICK, 3'b001);
    adv(1);    check("sw_e9_tick", TICK, 3'b000);
    adv(1);    check("sw_e10_tick", TICK, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
